// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    // Controller states; 2-bit encoding keeps the state register minimal.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_t;

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// Single-bit full adder cell, reused once per clock by the serial datapath.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum is the three-input parity; carry is the three-input majority.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands accepted on a valid/ready handshake,
// summed LSB-first through one full-adder cell, result presented on a second
// valid/ready handshake. Sum and carry-out only update when a result completes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter needs at least one bit so WIDTH=1 still has a legal register.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    sa_state_t r_state;
    sa_state_t w_state_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res_next;
    logic             w_accept;
    logic             w_last;

    // The one and only arithmetic cell; fed by the LSBs of the operand shifters.
    full_adder_bit u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    // New sum bit enters at the MSB so after WIDTH steps bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_s;
        end else begin : g_res_wn
            assign w_res_next = {w_s, r_res[WIDTH-1:1]};
        end
    endgenerate

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_last    = (r_cnt == LAST_STEP);
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, finish after WIDTH steps, drain in DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, shift one bit per RUN cycle, publish on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_res   <= w_res_next;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_c;
            end
        end
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder: accepts two WIDTH-bit unsigned operands through a valid/ready handshake and adds them LSB-first, one bit per clock, through a single full-adder cell. It presents the WIDTH-bit sum and carry-out through a second valid/ready handshake. It is the additive counterpart to the half-subtractor arithmetic cells. It serves as a small-area arithmetic unit where latency matters less than gate count.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..64.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  sum/cout are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  (a + b) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: serial addition in progress.
  - DONE: out_valid=1, result held.
- IDLE→RUN on in_valid && in_ready.
  - a and b are captured into shift registers.
  - Carry register is cleared to 0.
  - Bit counter is cleared to 0.
  - in_valid while not in IDLE is ignored; a/b are not sampled.
- RUN, each cycle:
  - s = a_sh[0]^b_sh[0]^c.
  - c' = majority(a_sh[0], b_sh[0], c).
  - a_sh and b_sh shift right by 1.
  - s is shifted into the MSB of the result register (result shifts right).
  - Counter increments.
- RUN→DONE on the cycle the counter reaches WIDTH-1, i.e. after exactly WIDTH bit-steps.
  - The final carry is registered as cout.
- DONE→IDLE on out_ready.
  - sum/cout hold stable for the whole time out_valid is high.
  - With out_ready low, the block stays in DONE indefinitely.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the (WIDTH+1)th bit.
  - Example: with WIDTH=8, 0xFF+0xFF gives sum=0xFE, cout=1.
- Reset (any time, including mid-RUN or in DONE):
  - State→IDLE, in_ready=1, out_valid=0, sum=0, cout=0.
  - Counter, carry and shift registers are cleared.
  - Any partial result is discarded; no out_valid pulse follows reset.
- WIDTH=1: RUN lasts a single cycle; the behaviour is otherwise identical.

## Timing
- All outputs are registered or decoded directly from the state register; there are no combinational input-to-output paths.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept at rising edge E0.
  - RUN covers edges E1..EWIDTH.
  - out_valid rises after edge EWIDTH, i.e. WIDTH cycles after the accept edge.
- DONE with out_ready=1 at edge Ek → IDLE after Ek.
  - in_ready is high from Ek, so the next accept is at Ek+1 at the earliest.
  - Minimum initiation interval is WIDTH+2 cycles.
- sum/cout change only on the RUN→DONE transition and on reset.
  - They keep their last value in IDLE until the next result is produced.
- Reset deassertion: first accept is possible on the first rising edge with rst low.

## Structure
- Package serial_adder_pkg holds the state typedef (IDLE, RUN, DONE; 2-bit encoding).
- The counter width is $clog2(WIDTH) with a minimum of 1, computed locally from WIDTH.
- Sub-module full_adder_bit: combinational cell with inputs a, b, cin and outputs s, cout. It is instantiated once in RUN datapath.
- Top level contains:
  - the FSM;
  - the a/b/result shift registers;
  - the carry register;
  - the counter;
  - the cout register.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, out_ready=1 → out_valid rises 8 cycles after accept; sum=0x8D, cout=0; in_ready returns 1 one cycle later.
- WIDTH=8, a=0xFF, b=0x01 → sum=0x00, cout=1. Then a=0xFF, b=0xFF → sum=0xFE, cout=1.
- Backpressure: out_ready held 0 for 5 cycles in DONE → out_valid, sum and cout are stable throughout and in_ready=0. Releasing out_ready gives a single handoff.
- in_valid held high with new operands (a=0x01, b=0x01) during RUN of 0x10+0x20 → result is 0x30; the second pair is accepted only after return to IDLE and yields 0x02.
- Assert rst at bit-step 4 of 0xAA+0x55 → outputs reset immediately (out_valid=0, sum=0, cout=0, in_ready=1); no result appears; a subsequent 0x0F+0x01 yields 0x10.
- WIDTH=1 build: 1+1 → sum=0, cout=1, out_valid 1 cycle after accept. 1+0 → sum=1, cout=0.
